// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared types for the decode-stage immediate generator:
//               immediate format select encoding and skid-buffer occupancy
//               states.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Immediate format select, as driven on imm_src by the decoder.
    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_Z     = 3'b110,
        IMM_ILL   = 3'b111
    } imm_src_e;

    // Number of entries held by the two-deep output skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam int ILEN_FIXED = 32;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational immediate extraction for all RV32I/RV64I
//               formats, sign- or zero-extended to XLEN bits.
// Ports       : instr_i    - raw 32-bit instruction word
//               imm_src_i  - immediate format select (imm_src_e encoding)
//               imm_o      - extended immediate (0 for an illegal select)
//               err_o      - high when imm_src_i is the illegal encoding
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      imm_src_i,
    output logic [XLEN-1:0] imm_o,
    output logic            err_o
);

    // The opcode field never contributes to an immediate.
    logic w_unused_opcode;
    assign w_unused_opcode = ^instr_i[6:0];

    // Sign extension is done by casting a signed field up to XLEN bits; on
    // RV64 this also replicates instr[31] into bits 63:32 for the U format.
    always_comb begin
        imm_o = '0;
        err_o = 1'b0;
        case (imm_src_e'(imm_src_i))
            IMM_I: imm_o = XLEN'($signed(instr_i[31:20]));
            IMM_S: imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            IMM_B: imm_o = XLEN'($signed({instr_i[31], instr_i[7],
                                          instr_i[30:25], instr_i[11:8],
                                          1'b0}));
            IMM_J: imm_o = XLEN'($signed({instr_i[31], instr_i[19:12],
                                          instr_i[20], instr_i[30:21],
                                          1'b0}));
            IMM_U: imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
            IMM_SHAMT: begin
                // RV64 shift amounts are six bits wide, RV32 five.
                if (XLEN == 64) begin
                    imm_o = XLEN'(instr_i[25:20]);
                end else begin
                    imm_o = XLEN'(instr_i[24:20]);
                end
            end
            IMM_Z: imm_o = XLEN'(instr_i[19:15]);
            default: begin
                imm_o = '0;
                err_o = 1'b1;
            end
        endcase
    end

endmodule : imm_decode
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : Registered immediate generator for the decode stage. Decodes
//               the immediate, adds it to the instruction's pc, and presents
//               the result through a two-entry skid buffer so that in_ready
//               never depends combinationally on out_ready.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_valid/in_ready   - upstream handshake (instr, imm_src, pc)
//               flush               - drop every held entry
//               out_valid/out_ready - downstream handshake
//               imm_op, pc_target,
//               imm_err             - result of the entry at the head
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] instr,
    input  logic [2:0]      imm_src,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_op,
    output logic [XLEN-1:0] pc_target,
    output logic            imm_err
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end
    if (ILEN != ILEN_FIXED) begin : g_bad_ilen
        $error("imm_gen_stage: ILEN must be 32");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            err;
    } entry_t;

    skid_state_e state_q, state_d;
    entry_t      out_q,   out_d;
    entry_t      skid_q,  skid_d;

    logic [XLEN-1:0] w_imm;
    logic            w_err;
    entry_t          w_new;
    logic            w_accept;
    logic            w_pop;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (instr),
        .imm_src_i (imm_src),
        .imm_o     (w_imm),
        .err_o     (w_err)
    );

    // The target is formed on the input side so it travels with its entry.
    assign w_new.imm    = w_imm;
    assign w_new.target = pc + w_imm;
    assign w_new.err    = w_err;

    assign in_ready  = (state_q != SKID_TWO);
    assign out_valid = (state_q != SKID_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // The output register always holds the oldest entry; the skid register
    // only ever holds the younger one while the output is stalled.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data registers keep their stale contents; only occupancy clears.
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        state_d = SKID_ONE;
                        out_d   = w_new;
                    end
                end
                SKID_ONE: begin
                    if (w_accept && w_pop) begin
                        out_d = w_new;
                    end else if (w_accept) begin
                        state_d = SKID_TWO;
                        skid_d  = w_new;
                    end else if (w_pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (w_pop) begin
                        state_d = SKID_ONE;
                        out_d   = skid_q;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign imm_op    = out_q.imm;
    assign pc_target = out_q.target;
    assign imm_err   = out_q.err;

endmodule : imm_gen_stage
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_stage
// Description : Self-checking bench for imm_gen_stage. Drives an RV32 and an
//               RV64 instance with the same instruction stream and compares
//               both against a reference queue model every cycle, plus
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [31:0] pc;
    logic [63:0] pc64;
    logic        flush;
    logic        out_ready;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32, tgt32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64, tgt64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    assign pc64 = {32'h0000_0001, pc};

    imm_gen_stage #(.XLEN(32), .ILEN(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .instr     (instr),
        .imm_src   (imm_src),
        .pc        (pc),
        .flush     (flush),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .imm_op    (imm32),
        .pc_target (tgt32),
        .imm_err   (err32)
    );

    imm_gen_stage #(.XLEN(64), .ILEN(32)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .instr     (instr),
        .imm_src   (imm_src),
        .pc        (pc64),
        .flush     (flush),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .imm_op    (imm64),
        .pc_target (tgt64),
        .imm_err   (err64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Immediate value computed arithmetically from the field layout of each
    // format: high fields are scaled by their bit position and the sign is
    // carried by an arithmetic shift of the sign-extended instruction word.
    function automatic exp_t ref_entry(input logic [31:0] ins, input logic [2:0] src,
                                       input logic [63:0] p, input int xl);
        longint s;
        longint v;
        exp_t   e;
        s     = longint'($signed(ins));
        e.err = 1'b0;
        case (src)
            3'd0: v = s >>> 20;
            3'd1: v = (s >>> 25) * 32 + longint'(ins[11:7]);
            3'd2: v = (s >>> 31) * 4096 + longint'(ins[7]) * 2048
                      + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            3'd3: v = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                      + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            3'd4: v = (s >>> 12) * 4096;
            3'd5: v = (xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6: v = longint'(ins[19:15]);
            default: begin
                v     = 0;
                e.err = 1'b1;
            end
        endcase
        e.imm = v;
        e.tgt = p + v;
        if (xl == 32) begin
            e.imm = {32'h0, e.imm[31:0]};
            e.tgt = {32'h0, e.tgt[31:0]};
        end
        return e;
    endfunction

    // Reference occupancy model: a FIFO of at most two results.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q32.delete();
            q64.delete();
        end else begin
            automatic bit acc = in_valid && (q32.size() < 2);
            automatic bit pop = (q32.size() > 0) && out_ready;
            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (pop) begin
                    void'(q32.pop_front());
                    void'(q64.pop_front());
                end
                if (acc) begin
                    q32.push_back(ref_entry(instr, imm_src, {32'h0, pc}, 32));
                    q64.push_back(ref_entry(instr, imm_src, pc64, 64));
                end
            end
        end
    end

    // Compare process: handshake every cycle, data whenever out_valid holds.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid32", {63'h0, out_valid32}, {63'h0, q32.size() != 0});
            chk("in_ready32",  {63'h0, in_ready32},  {63'h0, q32.size() < 2});
            chk("out_valid64", {63'h0, out_valid64}, {63'h0, q64.size() != 0});
            chk("in_ready64",  {63'h0, in_ready64},  {63'h0, q64.size() < 2});
            if (q32.size() != 0 && out_valid32) begin
                chk("imm32", {32'h0, imm32}, q32[0].imm);
                chk("tgt32", {32'h0, tgt32}, q32[0].tgt);
                chk("err32", {63'h0, err32}, {63'h0, q32[0].err});
            end
            if (q64.size() != 0 && out_valid64) begin
                chk("imm64", imm64, q64[0].imm);
                chk("tgt64", tgt64, q64[0].tgt);
                chk("err64", {63'h0, err64}, {63'h0, q64[0].err});
            end
        end
    end

    task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = i;
        imm_src  = s;
        pc       = p;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; imm_src = '0; pc = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst out_valid", {63'h0, out_valid32}, 64'h0);
        chk("rst in_ready",  {63'h0, in_ready32},  64'h1);
        chk("rst imm_op",    {32'h0, imm32},       64'h0);
        chk("rst pc_target", {32'h0, tgt32},       64'h0);
        chk("rst imm_err",   {63'h0, err32},       64'h0);
        chk("rst imm64",     imm64,                64'h0);

        // Basic I / B / J results, one per cycle.
        drive(32'hFFF0_0093, 3'b000, 32'h100);
        cyc();
        chk("addi valid", {63'h0, out_valid32}, 64'h1);
        chk("addi imm",   {32'h0, imm32}, 64'hFFFF_FFFF);
        chk("addi tgt",   {32'h0, tgt32}, 64'h0000_00FF);
        chk("addi err",   {63'h0, err32}, 64'h0);
        chk("addi imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi tgt64", tgt64, 64'h0000_0001_0000_00FF);
        drive(32'hFE00_0EE3, 3'b010, 32'h200);
        cyc();
        chk("beq imm", {32'h0, imm32}, 64'hFFFF_FFFC);
        chk("beq tgt", {32'h0, tgt32}, 64'h0000_01FC);
        drive(32'h0010_006F, 3'b011, 32'h1000);
        cyc();
        chk("jal imm", {32'h0, imm32}, 64'h0000_0800);
        chk("jal tgt", {32'h0, tgt32}, 64'h0000_1800);
        in_valid = 1'b0;
        cyc();

        // Backpressure: A and B fill the buffer, C waits upstream.
        out_ready = 1'b0;
        drive(32'h0010_0093, 3'b000, 32'h0);
        cyc();
        drive(32'h0020_0093, 3'b000, 32'h0);
        cyc();
        chk("full in_ready", {63'h0, in_ready32}, 64'h0);
        drive(32'h0030_0093, 3'b000, 32'h0);
        cyc();
        cyc();
        chk("stall head A", {32'h0, imm32}, 64'h1);
        out_ready = 1'b1;
        cyc();
        chk("drain B", {32'h0, imm32}, 64'h2);
        cyc();
        chk("drain C", {32'h0, imm32}, 64'h3);
        in_valid = 1'b0;
        cyc();
        chk("drained", {63'h0, out_valid32}, 64'h0);

        // Flush from the full state with a concurrent input.
        out_ready = 1'b0;
        drive(32'h0040_0093, 3'b000, 32'h10);
        cyc();
        drive(32'h0050_0093, 3'b000, 32'h20);
        cyc();
        drive(32'h0070_0093, 3'b000, 32'h30);
        flush = 1'b1;
        cyc();
        chk("flush out_valid", {63'h0, out_valid32}, 64'h0);
        chk("flush in_ready",  {63'h0, in_ready32},  64'h1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("post flush", {63'h0, out_valid32}, 64'h0);

        // Remaining formats back-to-back.
        drive(32'h1234_5678, 3'b111, 32'h40);
        cyc();
        chk("ill imm", {32'h0, imm32}, 64'h0);
        chk("ill err", {63'h0, err32}, 64'h1);
        drive(32'h01F0_1013, 3'b101, 32'h0);
        cyc();
        chk("shamt31 imm",   {32'h0, imm32}, 64'h1F);
        chk("shamt31 imm64", imm64,          64'h1F);
        drive(32'h03F0_1013, 3'b101, 32'h0);
        cyc();
        chk("shamt63 imm32", {32'h0, imm32}, 64'h1F);
        chk("shamt63 imm64", imm64,          64'h3F);
        drive(32'h8000_00B7, 3'b100, 32'h0);
        cyc();
        chk("lui imm32", {32'h0, imm32}, 64'h8000_0000);
        chk("lui imm64", imm64,          64'hFFFF_FFFF_8000_0000);
        drive(32'hFE11_2E23, 3'b001, 32'h300);
        cyc();
        chk("sw imm", {32'h0, imm32}, 64'hFFFF_FFFC);
        chk("sw tgt", {32'h0, tgt32}, 64'h0000_02FC);
        drive(32'h340F_D073, 3'b110, 32'h0);
        cyc();
        chk("csr uimm", {32'h0, imm32}, 64'h1F);
        in_valid = 1'b0;
        cyc();

        // Asynchronous reset while holding a valid entry.
        out_ready = 1'b0;
        drive(32'h0050_0093, 3'b000, 32'h40);
        cyc();
        in_valid = 1'b0;
        chk("pre-reset valid", {63'h0, out_valid32}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", {63'h0, out_valid32}, 64'h0);
        chk("async imm",       {32'h0, imm32},       64'h0);
        chk("async tgt",       {32'h0, tgt32},       64'h0);
        chk("async tgt64",     tgt64,                64'h0);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("post-reset in_ready", {63'h0, in_ready32}, 64'h1);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imm_gen_stage
`default_nettype wire
